// File: rtl/ecc_sync_fifo.sv
// Single-clock FIFO with Hamming-protected storage, peek/pop reads and saturating error counters.
// Define FIFO_ECC_DED_EN to add an overall-parity bit (SECDED); otherwise SEC only.
module ecc_sync_fifo #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR      = 4,
  parameter int unsigned AF_THRESH = 12,
  parameter int unsigned AE_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             inj_en,
  input  logic [7:0]       inj_bit,
  input  logic             rd_en,
  input  logic             rd_peek,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [7:0]       rd_err_idx,
  output logic             rd_sec_err,
  output logic             rd_ded_err,
  output logic [ADDR:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr,
  output logic [15:0]      sec_cnt,
  output logic [15:0]      ded_cnt
);

  function automatic int unsigned calc_par(input int unsigned w);
    int unsigned p;
    p = 0;
    for (int unsigned i = 1; i < 16; i++)
      if (p == 0 && (32'd1 << i) >= w + i + 1) p = i;
    return p;
  endfunction

  localparam int unsigned DEPTH = 1 << ADDR;
  localparam int unsigned CNTW  = ADDR + 1;
  localparam int unsigned PAR_H = calc_par(WIDTH);
`ifdef FIFO_ECC_DED_EN
  localparam int unsigned DED   = 1;
`else
  localparam int unsigned DED   = 0;
`endif
  localparam int unsigned PAR   = PAR_H + DED;
  localparam int unsigned NH    = WIDTH + PAR_H;  // Hamming positions 1..NH
  localparam int unsigned CW    = WIDTH + PAR;
  localparam int unsigned SW    = 8;

  // Syndrome: XOR of the 1-based positions of all set Hamming bits.
  function automatic logic [SW-1:0] syndrome(input logic [CW-1:0] c);
    logic [SW-1:0] s;
    s = '0;
    for (int unsigned q = 1; q <= NH; q++)
      if (c[q-1]) s ^= SW'(q);
    return s;
  endfunction

  // Data fills non-power-of-2 positions; parity bits then zero the syndrome.
  function automatic logic [CW-1:0] encode(input logic [WIDTH-1:0] d);
    logic [CW-1:0] c;
    logic [SW-1:0] s;
    int unsigned   j;
    c = '0;
    j = 0;
    for (int unsigned q = 1; q <= NH; q++) begin
      if ((q & (q - 1)) != 0) begin
        c[q-1] = d[j];
        j++;
      end
    end
    s = syndrome(c);
    for (int unsigned k = 0; k < PAR_H; k++)
      c[(32'd1 << k) - 32'd1] = s[k];
`ifdef FIFO_ECC_DED_EN
    c[CW-1] = ^c[NH-1:0];
`endif
    return c;
  endfunction

  function automatic logic [WIDTH-1:0] extract(input logic [CW-1:0] c);
    logic [WIDTH-1:0] d;
    int unsigned      j;
    d = '0;
    j = 0;
    for (int unsigned q = 1; q <= NH; q++) begin
      if ((q & (q - 1)) != 0) begin
        d[j] = c[q-1];
        j++;
      end
    end
    return d;
  endfunction

  logic [CW-1:0]    mem [DEPTH];
  logic [ADDR-1:0]  wr_ptr, rd_ptr;
  logic             rd_acc_c, pop_c, wr_acc_c, flip_c, sec_c, ded_c;
  logic [CNTW-1:0]  count_nxt_c;
  logic [CW-1:0]    wr_cw_c, rd_cw_c, fix_cw_c;
  logic [SW-1:0]    syn_c;
  logic [WIDTH-1:0] rd_dec_c;

  // Request acceptance; a same-cycle pop frees a slot for a write into a full FIFO.
  always_comb begin
    rd_acc_c    = rd_en && !empty;
    pop_c       = rd_acc_c && !rd_peek;
    wr_acc_c    = wr_en && (!full || pop_c);
    count_nxt_c = count;
    if (wr_acc_c && !pop_c)      count_nxt_c = count + CNTW'(1);
    else if (pop_c && !wr_acc_c) count_nxt_c = count - CNTW'(1);
  end

  always_comb begin
    wr_cw_c = encode(wr_data);
    if (inj_en)
      for (int unsigned q = 0; q < CW; q++)
        if (inj_bit == SW'(q)) wr_cw_c[q] = ~wr_cw_c[q];
  end

  // Decode the head word; out-of-range syndromes match no position and flip nothing.
  always_comb begin
    rd_cw_c  = mem[rd_ptr];
    syn_c    = syndrome(rd_cw_c);
    fix_cw_c = rd_cw_c;
    sec_c    = 1'b0;
    ded_c    = 1'b0;
    flip_c   = 1'b0;
`ifdef FIFO_ECC_DED_EN
    if (syn_c != '0 && !(^rd_cw_c)) begin
      ded_c = 1'b1;
    end else if (syn_c != '0 || (^rd_cw_c)) begin
      sec_c  = 1'b1;
      flip_c = (syn_c != '0);
    end
`else
    if (syn_c != '0) begin
      sec_c  = 1'b1;
      flip_c = 1'b1;
    end
`endif
    if (flip_c)
      for (int unsigned q = 1; q <= NH; q++)
        if (syn_c == SW'(q)) fix_cw_c[q-1] = ~fix_cw_c[q-1];
    rd_dec_c = extract(fix_cw_c);
  end

  // Storage is not reset; non-blocking write keeps full write+pop read-first.
  always_ff @(posedge clk) begin
    if (wr_acc_c) mem[wr_ptr] <= wr_cw_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      rd_err_idx   <= '0;
      rd_sec_err   <= 1'b0;
      rd_ded_err   <= 1'b0;
    end else begin
      if (wr_acc_c) wr_ptr <= wr_ptr + ADDR'(1);
      if (pop_c)    rd_ptr <= rd_ptr + ADDR'(1);
      count        <= count_nxt_c;
      full         <= (count_nxt_c == CNTW'(DEPTH));
      empty        <= (count_nxt_c == '0);
      almost_full  <= (count_nxt_c >= CNTW'(AF_THRESH));
      almost_empty <= (count_nxt_c <= CNTW'(AE_THRESH));
      overflow     <= wr_en && !wr_acc_c;
      underflow    <= rd_en && empty;
      rd_valid     <= rd_acc_c;
      rd_sec_err   <= rd_acc_c && sec_c;
      rd_ded_err   <= rd_acc_c && ded_c;
      if (rd_acc_c) begin
        rd_data    <= rd_dec_c;
        rd_err_idx <= syn_c;
      end
    end
  end

  // Error counters saturate; clear has priority over an increment.
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else begin
      if (rd_sec_err && sec_cnt != 16'hFFFF) sec_cnt <= sec_cnt + 16'd1;
      if (rd_ded_err && ded_cnt != 16'hFFFF) ded_cnt <= ded_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ecc_sync_fifo.sv
// Bench for ecc_sync_fifo: directed vector table, randomized run against a queue model,
// and (with FIFO_ECC_DED_EN) a double-error sequence.
module tb_ecc_sync_fifo;

  localparam int unsigned NH = 38;
`ifdef FIFO_ECC_DED_EN
  localparam int unsigned CW = 39;
`else
  localparam int unsigned CW = 38;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, inj_en = 1'b0, rd_en = 1'b0, rd_peek = 1'b0, err_clr = 1'b0;
  logic [31:0] wr_data = '0;
  logic [7:0]  inj_bit = '0;
  logic        rd_valid, rd_sec_err, rd_ded_err;
  logic [31:0] rd_data;
  logic [7:0]  rd_err_idx;
  logic [4:0]  count;
  logic        full, empty, almost_full, almost_empty, overflow, underflow;
  logic [15:0] sec_cnt, ded_cnt;

  ecc_sync_fifo dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .inj_en(inj_en),
    .inj_bit(inj_bit), .rd_en(rd_en), .rd_peek(rd_peek), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_err_idx(rd_err_idx), .rd_sec_err(rd_sec_err),
    .rd_ded_err(rd_ded_err), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .overflow(overflow),
    .underflow(underflow), .err_clr(err_clr), .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] wd;
    logic        inj;
    logic [7:0]  ib;
    logic        rd;
    logic        pk;
    logic        clr;
    logic        e_valid;
    logic [31:0] e_data;
    logic [7:0]  e_idx;
    logic        e_sec;
    logic [4:0]  e_count;
    logic        e_ovf;
    logic        e_unf;
    logic [15:0] e_scnt;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  idx;
    logic        sec;
  } ent_t;

  vec_t vt[$];
  ent_t mq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void row(input logic wr, input logic [31:0] wd, input logic inj,
                              input logic [7:0] ib, input logic rd, input logic pk,
                              input logic clr, input logic ev, input logic [31:0] ed,
                              input logic [7:0] ei, input logic es, input logic [4:0] ec,
                              input logic eov, input logic eun, input logic [15:0] esc,
                              input string nm);
    vec_t v;
    v.wr = wr; v.wd = wd; v.inj = inj; v.ib = ib; v.rd = rd; v.pk = pk; v.clr = clr;
    v.e_valid = ev; v.e_data = ed; v.e_idx = ei; v.e_sec = es; v.e_count = ec;
    v.e_ovf = eov; v.e_unf = eun; v.e_scnt = esc; v.name = nm;
    vt.push_back(v);
  endfunction

  task automatic drive(input logic wr, input logic [31:0] wd, input logic inj,
                       input logic [7:0] ib, input logic rd, input logic pk, input logic clr);
    wr_en = wr; wr_data = wd; inj_en = inj; inj_bit = ib;
    rd_en = rd; rd_peek = pk; err_clr = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_flags(input string nm, input int ec);
    chk({nm, ":count"}, count, 64'(ec));
    chk({nm, ":full"}, full, 64'(ec == 16));
    chk({nm, ":empty"}, empty, 64'(ec == 0));
    chk({nm, ":afull"}, almost_full, 64'(ec >= 12));
    chk({nm, ":aempty"}, almost_empty, 64'(ec <= 4));
  endtask

  initial begin
    logic        wr, rd, pk, inj, clr, e_acc, e_pop, e_wacc, m_pulse;
    logic [31:0] wd;
    logic [7:0]  ib;
    logic [15:0] m_cnt;
    ent_t        eh, en;
    int          wp;

    // Directed vectors
    for (int i = 0; i < 16; i++) row(1, 32'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'(i + 1), 0, 0, 0, "fill");
    row(1, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd16, 1, 0, 0, "overflow");
    for (int i = 0; i < 16; i++) row(0, 0, 0, 0, 1, 0, 0, 1, 32'(i), 0, 0, 5'(15 - i), 0, 0, 0, "drain");
    row(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 5'd0, 0, 1, 0, "underflow");
    row(1, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd1, 0, 0, 0, "t3_wr");
    row(0, 0, 0, 0, 1, 1, 0, 1, 32'hA5A5A5A5, 0, 0, 5'd1, 0, 0, 0, "peek1");
    row(0, 0, 0, 0, 1, 1, 0, 1, 32'hA5A5A5A5, 0, 0, 5'd1, 0, 0, 0, "peek2");
    row(0, 0, 0, 0, 1, 0, 0, 1, 32'hA5A5A5A5, 0, 0, 5'd0, 0, 0, 0, "peek_pop");
    row(1, 32'h12345678, 1, 8'd4, 0, 0, 0, 0, 0, 0, 0, 5'd1, 0, 0, 0, "inj_wr");
    row(0, 0, 0, 0, 1, 0, 0, 1, 32'h12345678, 8'd5, 1, 5'd0, 0, 0, 0, "sec_rd");
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 16'd1, "sec_cnt");
    row(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5'd0, 0, 0, 16'd0, "err_clr");
    row(1, 32'h0BADF00D, 1, 8'd45, 0, 0, 0, 0, 0, 0, 0, 5'd1, 0, 0, 0, "inj_oor_wr");
    row(0, 0, 0, 0, 1, 0, 0, 1, 32'h0BADF00D, 0, 0, 5'd0, 0, 0, 0, "inj_oor_rd");
    row(1, 32'h77, 0, 0, 1, 0, 0, 0, 0, 0, 0, 5'd1, 0, 1, 0, "wr_rd_empty");
    row(0, 0, 0, 0, 1, 0, 0, 1, 32'h77, 0, 0, 5'd0, 0, 0, 0, "no_bypass_rd");
    for (int i = 0; i < 16; i++) row(1, 32'h100 + 32'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'(i + 1), 0, 0, 0, "refill");
    row(1, 32'hBEEF, 0, 0, 1, 0, 0, 1, 32'h100, 0, 0, 5'd16, 0, 0, 0, "full_wr_pop");
    for (int i = 1; i < 16; i++) row(0, 0, 0, 0, 1, 0, 0, 1, 32'h100 + 32'(i), 0, 0, 5'(16 - i), 0, 0, 0, "after_wr_pop");
    row(0, 0, 0, 0, 1, 0, 0, 1, 32'hBEEF, 0, 0, 5'd0, 0, 0, 0, "new_word");

    do_reset();
    chk("rst:valid", rd_valid, 0);
    chk("rst:data", rd_data, 0);
    chk("rst:idx", rd_err_idx, 0);
    chk("rst:sec", rd_sec_err, 0);
    chk("rst:ded", rd_ded_err, 0);
    chk("rst:ovf", overflow, 0);
    chk("rst:unf", underflow, 0);
    chk("rst:scnt", sec_cnt, 0);
    chk("rst:dcnt", ded_cnt, 0);
    chk_flags("rst", 0);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].wr, vt[i].wd, vt[i].inj, vt[i].ib, vt[i].rd, vt[i].pk, vt[i].clr);
      tick();
      chk({vt[i].name, ":valid"}, rd_valid, vt[i].e_valid);
      if (vt[i].e_valid) begin
        chk({vt[i].name, ":data"}, rd_data, vt[i].e_data);
        chk({vt[i].name, ":idx"}, rd_err_idx, vt[i].e_idx);
      end
      chk({vt[i].name, ":sec"}, rd_sec_err, vt[i].e_sec);
      chk({vt[i].name, ":ded"}, rd_ded_err, 0);
      chk({vt[i].name, ":ovf"}, overflow, vt[i].e_ovf);
      chk({vt[i].name, ":unf"}, underflow, vt[i].e_unf);
      chk({vt[i].name, ":scnt"}, sec_cnt, vt[i].e_scnt);
      chk({vt[i].name, ":dcnt"}, ded_cnt, 0);
      chk_flags(vt[i].name, int'(vt[i].e_count));
    end

    // Randomized traffic against a queue model
    do_reset();
    mq.delete();
    m_pulse = 1'b0;
    m_cnt   = '0;
    for (int c = 0; c < 600; c++) begin
      wp  = ((c / 100) % 2 == 0) ? 70 : 30;
      wr  = ($urandom_range(99) < wp);
      rd  = ($urandom_range(99) < 100 - wp);
      pk  = ($urandom_range(3) == 0);
      inj = ($urandom_range(9) < 3);
      ib  = 8'($urandom_range(45));
      clr = ($urandom_range(19) == 0);
      wd  = $urandom;
      drive(wr, wd, inj, ib, rd, pk, clr);

      e_acc  = rd && mq.size() > 0;
      e_pop  = e_acc && !pk;
      e_wacc = wr && (mq.size() < 16 || e_pop);
      eh     = e_acc ? mq[0] : '{d: 0, idx: 0, sec: 0};
      m_cnt  = clr ? 16'd0 : ((m_pulse && m_cnt != 16'hFFFF) ? m_cnt + 16'd1 : m_cnt);
      m_pulse = e_acc && eh.sec;
      en.d = wd;
      if (inj && ib < NH)      begin en.idx = ib + 8'd1; en.sec = 1'b1; end
      else if (inj && ib < CW) begin en.idx = 8'd0;      en.sec = 1'b1; end
      else                     begin en.idx = 8'd0;      en.sec = 1'b0; end
      if (e_pop)  void'(mq.pop_front());
      if (e_wacc) mq.push_back(en);

      tick();
      chk("rnd:valid", rd_valid, e_acc);
      if (e_acc) begin
        chk("rnd:data", rd_data, eh.d);
        chk("rnd:idx", rd_err_idx, eh.idx);
      end
      chk("rnd:sec", rd_sec_err, m_pulse);
      chk("rnd:ded", rd_ded_err, 0);
      chk("rnd:ovf", overflow, wr && !e_wacc);
      chk("rnd:unf", underflow, rd && !e_acc);
      chk("rnd:scnt", sec_cnt, m_cnt);
      chk_flags("rnd", mq.size());
    end

`ifdef FIFO_ECC_DED_EN
    // Double error: bit 2 by injection, bit 9 flipped in storage afterwards
    do_reset();
    drive(1, 32'hCAFEF00D, 1, 8'd2, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    dut.mem[0][9] <= ~dut.mem[0][9];
    #1;
    drive(0, 0, 0, 0, 1, 0, 0);
    tick();
    chk("ded:valid", rd_valid, 1);
    chk("ded:ded", rd_ded_err, 1);
    chk("ded:sec", rd_sec_err, 0);
    chk("ded:idx", rd_err_idx, 8'd9);
    chk("ded:data", rd_data, 32'hCAFEF00D ^ 32'h21);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("ded:dcnt", ded_cnt, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("ded:clr", ded_cnt, 0);
    chk("ded:sclr", sec_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
